// File: rtl/uart_debug_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_debug_ctrl_if
//  Description : Bundles the UART byte channel (rx strobe, tx handshake) and
//                the single-master memory port used by uart_debug_ctrl.
//                master modport : the debug controller side
//                slave  modport : the UART / memory environment side
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_debug_ctrl_if;
    // UART receive side: one-cycle strobe per received byte
    logic        rx_valid;
    logic [7:0]  rx_data;
    // UART transmit side: valid/ready handshake
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    // Memory port: request held while waitrequest is high
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_waitrequest, mem_readdata,
        output tx_valid, tx_data, mem_write, mem_read, mem_address, mem_writedata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_waitrequest, mem_readdata,
        input  tx_valid, tx_data, mem_write, mem_read, mem_address, mem_writedata
    );
endinterface
`default_nettype wire

// File: rtl/uart_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_debug_ctrl
//  Description : UART debug-bus controller. While debug mode is enabled it
//                holds the CPU in reset and turns host byte commands into
//                single memory transactions:
//                  write : 0x57, addr[4], data[4]   (little-endian fields)
//                  read  : 0x52, addr[4]            -> 4 data bytes, LSB first
//  Ports       : clk, rst        clock, synchronous active-high reset
//                uart_debug_en   debug mode request (already synchronized)
//                cpu_hold        CPU held in reset / bus granted to this block
//                cmd_error       sticky: bad opcode or inter-byte timeout
//                bus             uart_debug_ctrl_if.master (UART + memory)
//  Options     : define UART_DEBUG_WRITE_ACK_EN to answer every completed
//                write with the single byte 0x4B.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_debug_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TOW            = 26
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               uart_debug_en,
    output logic              cpu_hold,
    output logic              cmd_error,
    uart_debug_ctrl_if.master bus
);

    localparam logic [7:0]     c_op_write     = 8'h57;
    localparam logic [7:0]     c_op_read      = 8'h52;
    localparam logic [7:0]     c_ack_byte     = 8'h4B;
    localparam logic [TOW-1:0] c_timeout_last = TOW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_WR   = 3'd3,
        ST_RD   = 3'd4,
        ST_TX   = 3'd5
`ifdef UART_DEBUG_WRITE_ACK_EN
        ,
        ST_ACK  = 3'd6
`endif
    } state_t;

    state_t          r_state;
    logic            r_is_write;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_data;      // write data while collecting, read data while sending
    logic [TOW-1:0]  r_timer;
    logic            r_en_d;
    logic            r_cpu_hold;
    logic            r_cmd_error;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;
    logic            r_mem_write;
    logic            r_mem_read;
    logic [31:0]     r_mem_address;
    logic [31:0]     r_mem_writedata;

    logic            w_rx;
    logic            w_tx_fire;
    logic            w_en_fall;
    logic            w_timeout;
    logic [31:0]     w_addr_next;
    logic [31:0]     w_data_next;

    assign w_rx        = bus.rx_valid & uart_debug_en;
    assign w_tx_fire   = r_tx_valid & bus.tx_ready;
    assign w_en_fall   = r_en_d & ~uart_debug_en;
    assign w_timeout   = (r_timer == c_timeout_last);
    // Little-endian fields: each new byte enters at the top and slides down
    assign w_addr_next = {bus.rx_data, r_addr[31:8]};
    assign w_data_next = {bus.rx_data, r_data[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_is_write      <= 1'b0;
            r_byte_cnt      <= 2'd0;
            r_addr          <= 32'd0;
            r_data          <= 32'd0;
            r_timer         <= '0;
            r_en_d          <= 1'b0;
            r_cpu_hold      <= 1'b0;
            r_cmd_error     <= 1'b0;
            r_tx_valid      <= 1'b0;
            r_tx_data       <= 8'd0;
            r_mem_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_address   <= 32'd0;
            r_mem_writedata <= 32'd0;
        end else begin
            r_en_d <= uart_debug_en;

            // Releasing the CPU waits for IDLE so an in-flight access and
            // its read-back always finish under our bus ownership.
            if (uart_debug_en) begin
                r_cpu_hold <= 1'b1;
            end else if (r_state == ST_IDLE) begin
                r_cpu_hold <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_rx) begin
                        r_byte_cnt <= 2'd0;
                        r_timer    <= '0;
                        if (bus.rx_data == c_op_write || bus.rx_data == c_op_read) begin
                            r_is_write <= (bus.rx_data == c_op_write);
                            r_state    <= ST_ADDR;
                        end else begin
                            r_cmd_error <= 1'b1;
                        end
                    end
                end

                ST_ADDR, ST_DATA: begin
                    if (!uart_debug_en) begin
                        // No further bytes can be accepted, so the partial
                        // command is abandoned rather than left to time out.
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end else if (w_rx) begin
                        r_timer    <= '0;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_state == ST_ADDR) begin
                            r_addr <= w_addr_next;
                            if (r_byte_cnt == 2'd3) begin
                                if (r_is_write) begin
                                    r_state <= ST_DATA;
                                end else begin
                                    r_state       <= ST_RD;
                                    r_mem_read    <= 1'b1;
                                    r_mem_address <= {w_addr_next[31:2], 2'b00};
                                end
                            end
                        end else begin
                            r_data <= w_data_next;
                            if (r_byte_cnt == 2'd3) begin
                                r_state         <= ST_WR;
                                r_mem_write     <= 1'b1;
                                r_mem_address   <= {r_addr[31:2], 2'b00};
                                r_mem_writedata <= w_data_next;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state     <= ST_IDLE;
                        r_timer     <= '0;
                        r_cmd_error <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TOW'(1);
                    end
                end

                ST_WR: begin
                    if (!bus.mem_waitrequest) begin
                        r_mem_write <= 1'b0;
`ifdef UART_DEBUG_WRITE_ACK_EN
                        r_state    <= ST_ACK;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= c_ack_byte;
`else
                        r_state    <= ST_IDLE;
`endif
                    end
                end

                ST_RD: begin
                    if (!bus.mem_waitrequest) begin
                        r_mem_read <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= bus.mem_readdata[7:0];
                        r_data     <= {8'h00, bus.mem_readdata[31:8]};
                        r_byte_cnt <= 2'd0;
                        r_state    <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (w_tx_fire) begin
                        if (r_byte_cnt == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            r_tx_data  <= r_data[7:0];
                            r_data     <= {8'h00, r_data[31:8]};
                        end
                    end
                end

`ifdef UART_DEBUG_WRITE_ACK_EN
                ST_ACK: begin
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
`endif

                default: r_state <= ST_IDLE;
            endcase

            // Leaving debug mode wipes the sticky error; last so it wins
            if (w_en_fall) begin
                r_cmd_error <= 1'b0;
            end
        end
    end

    assign cpu_hold          = r_cpu_hold;
    assign cmd_error         = r_cmd_error;
    assign bus.tx_valid      = r_tx_valid;
    assign bus.tx_data       = r_tx_data;
    assign bus.mem_write     = r_mem_write;
    assign bus.mem_read      = r_mem_read;
    assign bus.mem_address   = r_mem_address;
    assign bus.mem_writedata = r_mem_writedata;

endmodule
`default_nettype wire

// File: tb/tb_uart_debug_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_debug_ctrl
//  Description : Self-checking bench for uart_debug_ctrl: a memory responder
//                with configurable stalls, a UART TX sink with random
//                back-pressure, a table of directed commands, hand-written
//                corner sequences and random commands against a
//                host-level model (word memory + sticky error flag).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_debug_ctrl;

    localparam int         TIMEOUT_CYCLES = 100;
    localparam int         TOW            = 8;
    localparam logic [7:0] OP_WR          = 8'h57;
    localparam logic [7:0] OP_RD          = 8'h52;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_debug_en = 1'b0;
    logic cpu_hold;
    logic cmd_error;

    uart_debug_ctrl_if bus ();

    uart_debug_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TOW            (TOW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_debug_en (uart_debug_en),
        .cpu_hold      (cpu_hold),
        .cmd_error     (cmd_error),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, want);
        end
    endfunction

    // ---------------- memory responder ----------------
    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cycles;
    } bus_rec_t;

    logic [31:0] sys_mem [logic [31:0]];
    bus_rec_t    bus_log [$];
    int          stall_cfg  = 0;
    bit          stall_rand = 0;

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    initial begin : p_mem
        bit          active;
        int          left;
        int          cyc;
        logic [31:0] a0;
        logic [31:0] d0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 32'd0;
        active = 0; left = 0; cyc = 0; a0 = 0; d0 = 0;
        forever begin
            @(negedge clk);
            if (!rst && (bus.mem_write || bus.mem_read)) begin
                check("req_exclusive", 32'(bus.mem_write && bus.mem_read), 0);
                check("req_needs_hold", 32'(cpu_hold), 1);
                if (!active) begin
                    active = 1; cyc = 0;
                    a0 = bus.mem_address; d0 = bus.mem_writedata;
                    left = stall_rand ? int'($urandom_range(0, 3)) : stall_cfg;
                end else begin
                    check("req_addr_stable", bus.mem_address, a0);
                    if (bus.mem_write) check("req_wdata_stable", bus.mem_writedata, d0);
                end
                cyc++;
                bus.mem_waitrequest = (left > 0);
                if (left > 0) begin
                    left--;
                    bus.mem_readdata = $urandom;
                end else begin
                    if (bus.mem_write) begin
                        sys_mem[bus.mem_address] = bus.mem_writedata;
                        bus_log.push_back('{1'b1, bus.mem_address, bus.mem_writedata, cyc});
                    end else begin
                        bus.mem_readdata = sys_mem.exists(bus.mem_address) ?
                                           sys_mem[bus.mem_address] : mem_default(bus.mem_address);
                        bus_log.push_back('{1'b0, bus.mem_address, bus.mem_readdata, cyc});
                    end
                    active = 0;
                end
            end else begin
                active = 0;
                bus.mem_waitrequest = 1'b0;
            end
        end
    end

    // ---------------- UART TX sink ----------------
    bit         ready_rand = 0;
    logic [7:0] tx_got [$];

    initial begin : p_tx
        bit         pend;
        logic [7:0] pend_data;
        bus.tx_ready = 1'b0;
        pend = 0; pend_data = 0;
        forever begin
            @(negedge clk);
            if (pend && !rst) begin
                check("tx_valid_held", 32'(bus.tx_valid), 1);
                check("tx_data_held", 32'(bus.tx_data), 32'(pend_data));
            end
            bus.tx_ready = ready_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
            pend = 0;
            if (bus.tx_valid && !rst) begin
                if (bus.tx_ready) tx_got.push_back(bus.tx_data);
                else begin pend = 1; pend_data = bus.tx_data; end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        tick(gap);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input int gap_max);
        send_byte(op, $urandom_range(0, gap_max));
        if (op == OP_WR || op == OP_RD)
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], $urandom_range(0, gap_max));
        if (op == OP_WR)
            for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], (i == 3) ? 0 : $urandom_range(0, gap_max));
    endtask

    task automatic wait_log(input int want, input string name);
        int n = 0;
        while (bus_log.size() < want && n < 300) begin tick(1); n++; end
        if (bus_log.size() < want) check(name, 32'(bus_log.size()), 32'(want));
    endtask

    task automatic wait_tx(input int want, input string name);
        int n = 0;
        while (tx_got.size() < want && n < 300) begin tick(1); n++; end
        if (tx_got.size() < want) check(name, 32'(tx_got.size()), 32'(want));
    endtask

    // Runs one command and returns the bus transaction it caused and, for a
    // read, the 4 returned bytes assembled little-endian.
    task automatic do_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input int gap_max, output bus_rec_t rec, output logic [31:0] word);
        int lb = bus_log.size();
        int tb = tx_got.size();
        rec  = '{1'bx, 32'hx, 32'hx, -1};
        word = 32'hx;
        send_cmd(op, addr, data, gap_max);
        if (op == OP_WR) begin
            wait_log(lb + 1, "wr_timeout");
            if (bus_log.size() > lb) rec = bus_log[lb];
`ifdef UART_DEBUG_WRITE_ACK_EN
            wait_tx(tb + 1, "ack_timeout");
            if (tx_got.size() > tb) check("ack_byte", 32'(tx_got[tb]), 32'h4B);
            tick(3);
            check("ack_single_byte", 32'(tx_got.size()), 32'(tb + 1));
`else
            tick(3);
            check("no_tx_after_write", 32'(tx_got.size()), 32'(tb));
`endif
        end else if (op == OP_RD) begin
            wait_log(lb + 1, "rd_timeout");
            if (bus_log.size() > lb) rec = bus_log[lb];
            wait_tx(tb + 4, "rd_tx_timeout");
            if (tx_got.size() >= tb + 4)
                word = {tx_got[tb + 3], tx_got[tb + 2], tx_got[tb + 1], tx_got[tb]};
            tick(3);
        end else begin
            tick(3);
            check("badop_no_mem", 32'(bus_log.size()), 32'(lb));
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          stall;
        logic [31:0] exp_addr;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] ref_mem [logic [31:0]];

    initial begin : p_main
        bus_rec_t    rec;
        logic [31:0] word;
        int          lb, tb, n;
        bit          dropped;
        logic [7:0]  op;
        logic [31:0] addr, data, wa, expw;
        logic        exp_err;

        vecs[0] = '{OP_WR, 32'h10, 32'hDEADBEEF, 0, 32'h10, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{OP_WR, 32'h20, 32'h12345678, 2, 32'h20, 32'h12345678, 1'b0};
        vecs[2] = '{OP_RD, 32'h20, 32'h0,        3, 32'h20, 32'h12345678, 1'b0};
        vecs[3] = '{OP_RD, 32'h10, 32'h0,        0, 32'h10, 32'hDEADBEEF, 1'b0};
        vecs[4] = '{OP_WR, 32'h37, 32'hCAFEF00D, 1, 32'h34, 32'hCAFEF00D, 1'b0};
        vecs[5] = '{OP_RD, 32'h36, 32'h0,        0, 32'h34, 32'hCAFEF00D, 1'b0};
        vecs[6] = '{OP_RD, 32'h40, 32'h0,        1, 32'h40, 32'hA5A50040, 1'b0};
        vecs[7] = '{8'hFF, 32'h0,  32'h0,        0, 32'h0,  32'h0,        1'b1};
        vecs[8] = '{OP_WR, 32'h44, 32'h0BADC0DE, 0, 32'h44, 32'h0BADC0DE, 1'b1};
        vecs[9] = '{OP_RD, 32'h44, 32'h0,        2, 32'h44, 32'h0BADC0DE, 1'b1};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;

        // ---- reset values ----
        tick(3);
        check("rst_cpu_hold", 32'(cpu_hold), 0);
        check("rst_cmd_error", 32'(cmd_error), 0);
        check("rst_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_mem_write", 32'(bus.mem_write), 0);
        check("rst_mem_read", 32'(bus.mem_read), 0);
        check("rst_mem_address", bus.mem_address, 0);
        rst = 1'b0;
        tick(1);
        uart_debug_en = 1'b1;
        tick(1);
        check("hold_follows_en", 32'(cpu_hold), 1);
        tick(1);

        // ---- table ----
        ready_rand = 1;
        for (int i = 0; i < 10; i++) begin
            stall_cfg = vecs[i].stall;
            do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, 1, rec, word);
            if (vecs[i].op == OP_WR || vecs[i].op == OP_RD) begin
                check($sformatf("v%0d_is_wr", i), 32'(rec.is_wr), 32'(vecs[i].op == OP_WR));
                check($sformatf("v%0d_addr", i), rec.addr, vecs[i].exp_addr);
                check($sformatf("v%0d_req_cycles", i), 32'(rec.cycles), 32'(vecs[i].stall + 1));
                if (vecs[i].op == OP_WR) begin
                    check($sformatf("v%0d_wdata", i), rec.data, vecs[i].exp_word);
                    ref_mem[vecs[i].exp_addr] = vecs[i].data;
                end else begin
                    check($sformatf("v%0d_rdata", i), word, vecs[i].exp_word);
                end
            end
            check($sformatf("v%0d_cmd_error", i), 32'(cmd_error), 32'(vecs[i].exp_err));
        end

        // ---- debug_en fall clears the sticky error and releases the CPU ----
        uart_debug_en = 1'b0;
        tick(1);
        check("en_fall_clears_err", 32'(cmd_error), 0);
        check("en_fall_release", 32'(cpu_hold), 0);
        uart_debug_en = 1'b1;
        tick(2);

        // ---- 1-cycle turnaround, byte during RD dropped silently ----
        ready_rand = 0; stall_cfg = 4;
        tb = tx_got.size();
        send_cmd(OP_RD, 32'h10, 32'h0, 0);
        check("rd_turnaround", 32'(bus.mem_read), 1);
        send_byte(8'hFF, 0);
        wait_tx(tb + 4, "drop_rd_timeout");
        if (tx_got.size() >= tb + 4)
            check("drop_rd_word", {tx_got[tb + 3], tx_got[tb + 2], tx_got[tb + 1], tx_got[tb]}, 32'hDEADBEEF);
        tick(2);
        check("drop_rd_no_err", 32'(cmd_error), 0);

        // ---- inter-byte timeout ----
        send_byte(OP_WR, 0);
        send_byte(8'h01, 0);
        tick(TIMEOUT_CYCLES - 15);
        check("timeout_not_early", 32'(cmd_error), 0);
        tick(30);
        check("timeout_err", 32'(cmd_error), 1);
        lb = bus_log.size();
        stall_cfg = 0;
        do_cmd(OP_RD, 32'h20, 32'h0, 0, rec, word);
        check("after_timeout_rd", word, 32'h12345678);
        check("timeout_no_write", 32'(bus_log.size()), 32'(lb + 1));
        uart_debug_en = 1'b0; tick(2);
        uart_debug_en = 1'b1; tick(2);

        // ---- debug_en dropped during a stalled read ----
        ready_rand = 1; stall_cfg = 6;
        tb = tx_got.size();
        send_cmd(OP_RD, 32'h10, 32'h0, 0);
        uart_debug_en = 1'b0;
        send_byte(OP_WR, 0);
        dropped = 0; n = 0;
        while (tx_got.size() < tb + 4 && n < 300) begin
            if (!cpu_hold) dropped = 1;
            tick(1); n++;
        end
        check("hold_until_done", 32'(dropped), 0);
        check("hold_rd_bytes", 32'(tx_got.size()), 32'(tb + 4));
        if (tx_got.size() >= tb + 4)
            check("hold_rd_word", {tx_got[tb + 3], tx_got[tb + 2], tx_got[tb + 1], tx_got[tb]}, 32'hDEADBEEF);
        tick(3);
        check("hold_released", 32'(cpu_hold), 0);
        lb = bus_log.size(); tb = tx_got.size();
        send_cmd(OP_WR, 32'h10, 32'h11111111, 0);
        tick(5);
        check("dis_rx_ignored_mem", 32'(bus_log.size()), 32'(lb));
        check("dis_rx_ignored_tx", 32'(tx_got.size()), 32'(tb));
        check("dis_rx_no_err", 32'(cmd_error), 0);
        uart_debug_en = 1'b1;
        tick(2);

        // ---- random commands against the host-level model ----
        stall_rand = 1; ready_rand = 1; exp_err = 0;
        for (int k = 0; k < 40; k++) begin
            n    = $urandom_range(0, 9);
            addr = 32'h100 + $urandom_range(0, 63);
            data = $urandom;
            wa   = {addr[31:2], 2'b00};
            if (n == 0) begin
                do op = 8'($urandom); while (op == OP_WR || op == OP_RD);
                exp_err = 1;
            end else begin
                op = (n < 5) ? OP_WR : OP_RD;
            end
            do_cmd(op, addr, data, 2, rec, word);
            if (op == OP_WR) begin
                ref_mem[wa] = data;
                check("rnd_wr_addr", rec.addr, wa);
                check("rnd_wr_data", rec.data, data);
            end else if (op == OP_RD) begin
                expw = ref_mem.exists(wa) ? ref_mem[wa] : (wa ^ 32'hA5A5_0000);
                check("rnd_rd_addr", rec.addr, wa);
                check("rnd_rd_word", word, expw);
            end
            check("rnd_cmd_error", 32'(cmd_error), 32'(exp_err));
            if (exp_err && $urandom_range(0, 1) == 1) begin
                uart_debug_en = 1'b0; tick(2);
                uart_debug_en = 1'b1; tick(2);
                exp_err = 0;
            end
        end

        // ---- reset in the middle of a read-back ----
        stall_rand = 0; ready_rand = 0; stall_cfg = 0;
        send_byte(8'hAA, 2);
        check("pre_rst_err", 32'(cmd_error), 1);
        tb = tx_got.size();
        send_cmd(OP_RD, 32'h20, 32'h0, 0);
        n = 0;
        while (tx_got.size() < tb + 2 && n < 100) begin tick(1); n++; end
        check("pre_rst_two_bytes", 32'(tx_got.size() >= tb + 2), 1);
        rst = 1'b1;
        tick(1);
        check("midtx_tx_valid", 32'(bus.tx_valid), 0);
        check("midtx_mem_write", 32'(bus.mem_write), 0);
        check("midtx_mem_read", 32'(bus.mem_read), 0);
        check("midtx_cpu_hold", 32'(cpu_hold), 0);
        check("midtx_cmd_error", 32'(cmd_error), 0);
        rst = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : p_watchdog
        #500000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got simulation time limit, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
